// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register-dump controller: FSM state encoding and default sizing.
// Simple_Single_CPU and the bench import the same constants.
package reg_dump_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_CNT   = 12;
    localparam int END_COUNT = 5;
    localparam int CNT_W     = 32;

endpackage

// File: rtl/reg_dump_unit_run_cycle_counter.sv
// Counts CPU-enabled clock edges while running and decides when the CPU must be frozen.
// The count saturates instead of wrapping so a long run can never look like a short one.
module run_cycle_counter
    import reg_dump_unit_pkg::*;
#(
    parameter int CNT_W     = reg_dump_unit_pkg::CNT_W,
    parameter int END_COUNT = reg_dump_unit_pkg::END_COUNT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_en,
    input  logic             i_halt_req,
    output logic             o_run,
    output logic             o_halt,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] END_VAL = CNT_W'(END_COUNT);
    localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;
    logic             w_at_end;

    assign w_at_end = (r_count >= END_VAL);
    // A halt request wins over the run enable, so the halting edge is never a CPU edge.
    assign o_run    = i_en & ~w_at_end & ~i_halt_req;
    assign o_halt   = i_en & (w_at_end | i_halt_req);
    assign o_count  = r_count;

    // Saturating count of edges on which the CPU was enabled
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (o_run && (r_count != MAX_VAL)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_dump_unit.sv
// Runs the CPU for a bounded number of edges, freezes it, then streams registers
// 0..REG_CNT-1 out of the register file on a valid/ready word stream.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int DATA_W    = reg_dump_unit_pkg::DATA_W,
    parameter int ADDR_W    = reg_dump_unit_pkg::ADDR_W,
    parameter int REG_CNT   = reg_dump_unit_pkg::REG_CNT,
    parameter int END_COUNT = reg_dump_unit_pkg::END_COUNT,
    parameter int CNT_W     = reg_dump_unit_pkg::CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              halt_req_i,
    output logic              cpu_run_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic              dump_last_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycles_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_CNT - 1);

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_dump_idx;
    logic              r_last;
    logic              r_done;
    logic              w_in_run;
    logic              w_run;
    logic              w_halt;
    logic              w_handshake;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_handshake = (r_state == ST_SEND) & dump_ready_i;

    run_cycle_counter #(
        .CNT_W     (CNT_W),
        .END_COUNT (END_COUNT)
    ) u_run_cycle_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_en       (w_in_run),
        .i_halt_req (halt_req_i),
        .o_run      (w_run),
        .o_halt     (w_halt),
        .o_count    (cycles_o)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_halt) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_READ: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (dump_ready_i) begin
                    if (r_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Register index walks forward only after its word has been accepted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idx <= '0;
        end else if (w_handshake && !r_last) begin
            r_idx <= r_idx + ADDR_W'(1);
        end
    end

    // Stream word register: loaded in READ, held through SEND until accepted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_dump_idx <= '0;
            r_last     <= 1'b0;
        end else if (r_state == ST_READ) begin
            r_valid    <= 1'b1;
            r_data     <= rf_data_i;
            r_dump_idx <= r_idx;
            r_last     <= (r_idx == LAST_IDX);
        end else if (w_handshake) begin
            r_valid    <= 1'b0;
        end
    end

    // Sticky completion flag, registered one edge behind entry to DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_done <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_done <= 1'b1;
        end
    end

    assign cpu_run_o    = w_run;
    assign rf_addr_o    = r_idx;
    assign dump_valid_o = r_valid;
    assign dump_data_o  = r_data;
    assign dump_idx_o   = r_dump_idx;
    assign dump_last_o  = r_last;
    assign done_o       = r_done;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed-plus-random bench for reg_dump_unit: a main instance (END_COUNT=5, REG_CNT=12)
// and a corner instance (END_COUNT=0, REG_CNT=1), checked against an expected-word queue.
module tb_reg_dump_unit;
    import reg_dump_unit_pkg::*;

    localparam int E_CNT = 5;
    localparam int R_CNT = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt_req;
    logic        cpu_run;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
    logic        done;
    logic [31:0] cycles;

    logic        rst2_n;
    logic        halt2;
    logic        run2;
    logic [4:0]  addr2;
    logic [31:0] rdata2;
    logic        valid2;
    logic        ready2;
    logic [31:0] data2;
    logic [4:0]  idx2;
    logic        last2;
    logic        done2;
    logic [31:0] cycles2;

    logic [31:0] rf [0:31];
    int checks = 0;
    int errors = 0;

    assign rf_data = rf[rf_addr];
    assign rdata2  = rf[addr2];

    always #5 clk = ~clk;

    reg_dump_unit #(.DATA_W(32), .ADDR_W(5), .REG_CNT(R_CNT), .END_COUNT(E_CNT), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .halt_req_i(halt_req), .cpu_run_o(cpu_run),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data), .dump_valid_o(valid), .dump_ready_i(ready),
        .dump_data_o(data), .dump_idx_o(idx), .dump_last_o(last), .done_o(done), .cycles_o(cycles)
    );

    reg_dump_unit #(.DATA_W(32), .ADDR_W(5), .REG_CNT(1), .END_COUNT(0), .CNT_W(32)) dut_corner (
        .clk_i(clk), .rst_i(rst2_n), .halt_req_i(halt2), .cpu_run_o(run2),
        .rf_addr_o(addr2), .rf_data_i(rdata2), .dump_valid_o(valid2), .dump_ready_i(ready2),
        .dump_data_o(data2), .dump_idx_o(idx2), .dump_last_o(last2), .done_o(done2), .cycles_o(cycles2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full run/dump. halt_cyc<0: no halt request; abort_idx>=0: reset while that word is offered.
    task automatic run_scn(input int halt_cyc, input int max_stall, input int abort_idx);
        logic [31:0] exp_q[$];
        int          exp_cyc;
        int          runs;
        int          stall;
        int          first_valid;
        int          n;
        bit          held;
        logic [31:0] hd;
        logic [4:0]  hi;
        logic        hl;

        exp_cyc = (halt_cyc >= 0 && halt_cyc < E_CNT) ? halt_cyc : E_CNT;
        for (int i = 0; i < R_CNT; i++) exp_q.push_back(rf[i]);

        halt_req = 1'b0;
        ready    = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk); #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_idx", {27'd0, idx}, 32'd0);
        check("rst_last", {31'd0, last}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_addr", {27'd0, rf_addr}, 32'd0);

        @(negedge clk);
        rst_n       = 1'b1;
        runs        = 0;
        stall       = $urandom_range(0, max_stall);
        first_valid = -1;
        n           = 0;
        held        = 1'b0;
        for (int c = 0; c < 2000 && exp_q.size() > 0; c++) begin
            if (c > 0) @(negedge clk);
            halt_req = (c == halt_cyc);
            if (valid && stall > 0) begin
                ready = 1'b0;
                stall--;
            end else begin
                ready = 1'b1;
            end
            #1;
            if (cpu_run) runs++;
            if (valid) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    check("dump_start_cycle", c, exp_cyc + 2);
                end
                if (held) begin
                    check("stall_data", data, hd);
                    check("stall_idx", {27'd0, idx}, {27'd0, hi});
                    check("stall_last", {31'd0, last}, {31'd0, hl});
                end
                if (abort_idx >= 0 && int'(idx) == abort_idx) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_valid", {31'd0, valid}, 32'd0);
                    check("abort_idx", {27'd0, idx}, 32'd0);
                    check("abort_data", data, 32'd0);
                    check("abort_last", {31'd0, last}, 32'd0);
                    check("abort_cycles", cycles, 32'd0);
                    halt_req = 1'b0;
                    return;
                end
                if (ready) begin
                    check("word_data", data, exp_q[0]);
                    check("word_idx", {27'd0, idx}, n);
                    check("word_last", {31'd0, last}, (n == R_CNT - 1) ? 32'd1 : 32'd0);
                    void'(exp_q.pop_front());
                    n++;
                    held  = 1'b0;
                    stall = $urandom_range(0, max_stall);
                end else begin
                    held = 1'b1;
                    hd   = data;
                    hi   = idx;
                    hl   = last;
                end
            end
        end
        halt_req = 1'b0;
        check("words_left", exp_q.size(), 32'd0);
        check("run_edges", runs, exp_cyc);
        @(negedge clk); #1;
        check("done_early", {31'd0, done}, 32'd0);
        check("idle_valid1", {31'd0, valid}, 32'd0);
        @(negedge clk); #1;
        check("done_set", {31'd0, done}, 32'd1);
        check("idle_valid2", {31'd0, valid}, 32'd0);
        check("done_cpu_run", {31'd0, cpu_run}, 32'd0);
        check("cycles_final", cycles, exp_cyc);
    endtask

    initial begin
        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        halt_req = 1'b0;
        halt2    = 1'b0;
        ready    = 1'b0;
        ready2   = 1'b0;

        // Plain run, registers hold their own index, ready always high
        for (int i = 0; i < 32; i++) rf[i] = i;
        run_scn(-1, 0, -1);

        // Early halt in the third RUN cycle
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_scn(2, 0, -1);

        // Halt coinciding with the count reaching its end value
        run_scn(E_CNT, 1, -1);

        // Random backpressure
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_scn(-1, 4, -1);

        // Abort while word 6 is offered, then a fresh complete run
        run_scn(-1, 4, 6);
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_scn(-1, 2, -1);

        // Corner instance: no run cycles, single register
        @(negedge clk); #1;
        check("c_rst_valid", {31'd0, valid2}, 32'd0);
        check("c_rst_done", {31'd0, done2}, 32'd0);
        @(negedge clk);
        rst2_n = 1'b1;
        ready2 = 1'b1;
        #1;
        check("c_run_cyc0", {31'd0, run2}, 32'd0);
        @(negedge clk); #1;
        check("c_run_cyc1", {31'd0, run2}, 32'd0);
        check("c_valid_cyc1", {31'd0, valid2}, 32'd0);
        check("c_addr", {27'd0, addr2}, 32'd0);
        @(negedge clk); #1;
        check("c_valid", {31'd0, valid2}, 32'd1);
        check("c_data", data2, rf[0]);
        check("c_idx", {27'd0, idx2}, 32'd0);
        check("c_last", {31'd0, last2}, 32'd1);
        @(negedge clk); #1;
        check("c_valid_after", {31'd0, valid2}, 32'd0);
        check("c_done_early", {31'd0, done2}, 32'd0);
        @(negedge clk); #1;
        check("c_done", {31'd0, done2}, 32'd1);
        check("c_cycles", cycles2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
